// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq: multi-cycle ALU (arith/logic/shift/popcount/LUI/compare), one op per handshake.
// Latency: 2 clk single-cycle classes, count+1 clk shifts (min 2), WIDTH/HAM_CHUNK+1 clk popcount.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready. Option macro: ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int HAM_CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_sub,
  input  logic             const_var,
  input  logic [1:0]       logic_fn,
  input  logic [1:0]       shift_fn,
  input  logic [2:0]       fn_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
`endif
  output logic             overflow
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int CW     = SHW + 1;           // holds shift counts and chunk counts
  localparam int NCHUNK = WIDTH / HAM_CHUNK;

  localparam logic [2:0] C_ARITH = 3'b000;
  localparam logic [2:0] C_LOGIC = 3'b001;
  localparam logic [2:0] C_SHIFT = 3'b010;
  localparam logic [2:0] C_POPC  = 3'b011;
  localparam logic [2:0] C_LUI   = 3'b100;
  localparam logic [2:0] C_SLT   = 3'b101;
  localparam logic [2:0] C_SGT   = 3'b110;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;       // low until the first clock after reset release
  logic [WIDTH-1:0] r_x;          // operand A, also the shift / popcount working register
  logic [WIDTH-1:0] r_y;
  logic             r_add_sub;
  logic [1:0]       r_logic_fn;
  logic [1:0]       r_shift_fn;
  logic [2:0]       r_cls;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_res;
  logic             r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_yeff;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_lt;
  logic             w_gt;
  logic [WIDTH-1:0] w_sh;
  logic [WIDTH-1:0] w_chunk_ones;
  logic [WIDTH-1:0] w_pc_sum;
  logic             w_fin;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_ovf_nxt;

  assign w_accept = in_valid & in_ready;

  // Adder: subtraction as x + ~y + 1; overflow from operand/result sign agreement
  assign w_yeff = r_add_sub ? ~r_y : r_y;
`ifdef ALU_SEQ_FLAGS_EN
  logic w_cout;
  assign {w_cout, w_sum} = {1'b0, r_x} + {1'b0, w_yeff} + {{WIDTH{1'b0}}, r_add_sub};
`else
  assign w_sum = r_x + w_yeff + {{(WIDTH-1){1'b0}}, r_add_sub};
`endif
  assign w_add_ovf = (r_x[WIDTH-1] == w_yeff[WIDTH-1]) && (w_sum[WIDTH-1] != r_x[WIDTH-1]);

  // Full-precision signed compares, immune to subtraction overflow
  assign w_lt = $signed(r_x) < $signed(r_y);
  assign w_gt = $signed(r_x) > $signed(r_y);

  // One-bit shift step of the working register
  always_comb begin
    w_sh = r_x;
    case (r_shift_fn)
      SH_SLL:  w_sh = {r_x[WIDTH-2:0], 1'b0};
      SH_SRL:  w_sh = {1'b0, r_x[WIDTH-1:1]};
      SH_SRA:  w_sh = {r_x[WIDTH-1], r_x[WIDTH-1:1]};
      default: w_sh = {r_x[0], r_x[WIDTH-1:1]};
    endcase
  end

  // Count the ones in the lowest chunk of the working register
  always_comb begin
    w_chunk_ones = '0;
    for (int i = 0; i < HAM_CHUNK; i++) begin
      w_chunk_ones = w_chunk_ones + {{(WIDTH-1){1'b0}}, r_x[i]};
    end
  end

  assign w_pc_sum = r_pc + w_chunk_ones;

  // Per-class execute result and the "finishing this cycle" strobe
  always_comb begin
    w_fin     = 1'b0;
    w_res_nxt = '0;
    w_ovf_nxt = 1'b0;
    if (r_state == S_EXEC) begin
      w_fin = 1'b1;
      case (r_cls)
        C_ARITH: begin
          w_res_nxt = w_sum;
          w_ovf_nxt = w_add_ovf;
        end
        C_LOGIC: begin
          case (r_logic_fn)
            2'b00:   w_res_nxt = r_x & r_y;
            2'b01:   w_res_nxt = r_x | r_y;
            2'b10:   w_res_nxt = r_x ^ r_y;
            default: w_res_nxt = ~(r_x | r_y);
          endcase
        end
        C_SHIFT: begin
          // A zero count still spends one EXEC cycle and returns x untouched
          if (r_cnt == '0) begin
            w_res_nxt = r_x;
          end else begin
            w_res_nxt = w_sh;
            w_fin     = (r_cnt == CW'(1));
          end
        end
        C_POPC: begin
          w_res_nxt = w_pc_sum;
          w_fin     = (r_cnt == CW'(1));
        end
        C_LUI:   w_res_nxt = {r_y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        C_SLT:   w_res_nxt = {{(WIDTH-1){1'b0}}, w_lt};
        C_SGT:   w_res_nxt = {{(WIDTH-1){1'b0}}, w_gt};
        default: w_res_nxt = '0;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic w_cy_nxt;
  logic r_zero;
  logic r_neg;
  logic r_carry;

  // Carry source: adder carry-out, or the bit leaving the register on the last shift step
  always_comb begin
    w_cy_nxt = 1'b0;
    if (r_cls == C_ARITH) begin
      w_cy_nxt = w_cout;
    end else if ((r_cls == C_SHIFT) && (r_cnt != '0)) begin
      w_cy_nxt = (r_shift_fn == SH_SLL) ? r_x[WIDTH-1] : r_x[0];
    end
  end

  // Flags are captured together with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_fin) begin
      r_zero  <= (w_res_nxt == '0);
      r_neg   <= w_res_nxt[WIDTH-1];
      r_carry <= w_cy_nxt;
    end
  end

  assign zero_flag  = r_zero;
  assign neg_flag   = r_neg;
  assign carry_flag = r_carry;
`endif

  // State register; in_ready is held off until one clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
      S_EXEC:  if (w_fin)     w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = r_live;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, iterative shift/popcount stepping and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_add_sub  <= 1'b0;
      r_logic_fn <= 2'b00;
      r_shift_fn <= 2'b00;
      r_cls      <= 3'b000;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      r_x        <= x;
      r_y        <= y;
      r_add_sub  <= add_sub;
      r_logic_fn <= logic_fn;
      r_shift_fn <= shift_fn;
      r_cls      <= fn_class;
      r_pc       <= '0;
      if (fn_class == C_SHIFT) begin
        r_cnt <= const_var ? CW'(1) : {1'b0, y[SHW-1:0]};
      end else begin
        r_cnt <= CW'(NCHUNK);
      end
    end else if (r_state == S_EXEC) begin
      if ((r_cls == C_SHIFT) && (r_cnt != '0)) begin
        r_x   <= w_sh;
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_cls == C_POPC) begin
        r_x   <= r_x >> HAM_CHUNK;
        r_pc  <= w_pc_sum;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fin) begin
        r_res <= w_res_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign result   = r_res;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// tb_alu_seq: directed-vector self-checking bench for alu_seq (WIDTH=32, HAM_CHUNK=8).
// Latency is counted in clock edges from the accepting edge to the edge that raises out_valid.
// Covers reset, every class, shift/popcount latency, DONE backpressure and reset mid-operation.
module tb_alu_seq;

  localparam logic [2:0] C_ARITH = 3'b000;
  localparam logic [2:0] C_LOGIC = 3'b001;
  localparam logic [2:0] C_SHIFT = 3'b010;
  localparam logic [2:0] C_POPC  = 3'b011;
  localparam logic [2:0] C_LUI   = 3'b100;
  localparam logic [2:0] C_SLT   = 3'b101;
  localparam logic [2:0] C_SGT   = 3'b110;
  localparam logic [2:0] C_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        add_sub = 1'b0;
  logic        const_var = 1'b0;
  logic [1:0]  logic_fn = 2'b00;
  logic [1:0]  shift_fn = 2'b00;
  logic [2:0]  fn_class = 3'b000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
  logic        carry_flag;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(32), .HAM_CHUNK(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .add_sub    (add_sub),
    .const_var  (const_var),
    .logic_fn   (logic_fn),
    .shift_fn   (shift_fn),
    .fn_class   (fn_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
`ifdef ALU_SEQ_FLAGS_EN
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .carry_flag (carry_flag),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until the accepting edge
  task automatic issue(input logic [2:0] cls, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cv, input logic [1:0] lf, input logic [1:0] sf);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("issue_rdy", {31'b0, in_ready}, 32'd1);
    fn_class  = cls;
    x         = a;
    y         = b;
    add_sub   = sub;
    const_var = cv;
    logic_fn  = lf;
    shift_fn  = sf;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk("out_vld", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("vld_drop", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] cls, input logic [31:0] a,
                     input logic [31:0] b, input logic sub, input logic cv,
                     input logic [1:0] lf, input logic [1:0] sf,
                     input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
    int lat;
    issue(cls, a, b, sub, cv, lf, sf);
    wait_done(lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Arithmetic, reserved class and compares
    run("add_ovf", C_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h8000_0000, 1'b1, 2);
    run("rsvd",    C_RSVD,  32'h1234_5678, 32'h9, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 2);
    run("sub",     C_ARITH, 32'd5, 32'd7, 1'b1, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFE, 1'b0, 2);
    run("sub_ovf", C_ARITH, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 2'b00, 2'b00, 32'h7FFF_FFFF, 1'b1, 0);
    run("slt",     C_SLT,   32'd5, 32'd7, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1, 1'b0, 2);
    run("sgt",     C_SGT,   32'd5, 32'd7, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 2);
    run("slt_min", C_SLT,   32'h8000_0000, 32'h1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1, 1'b0, 0);
    run("sgt_max", C_SGT,   32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1, 1'b0, 0);

    // Logic functions
    run("and", C_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b00, 2'b00, 32'hF000_F000, 1'b0, 2);
    run("or",  C_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b01, 2'b00, 32'hFFF0_FFF0, 1'b0, 0);
    run("xor", C_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b10, 2'b00, 32'h0FF0_0FF0, 1'b0, 0);
    run("nor", C_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b11, 2'b00, 32'h000F_000F, 1'b0, 0);

    // Shifts: latency is count+1, with count 0 behaving like a single-cycle op
    run("sra4",  C_SHIFT, 32'h8000_0010, 32'd4,  1'b0, 1'b0, 2'b00, 2'b10, 32'hF800_0001, 1'b0, 5);
    run("sll0",  C_SHIFT, 32'h1234_5678, 32'd0,  1'b0, 1'b0, 2'b00, 2'b00, 32'h1234_5678, 1'b0, 2);
    run("sll_c", C_SHIFT, 32'h8000_0001, 32'd5,  1'b0, 1'b1, 2'b00, 2'b00, 32'h0000_0002, 1'b0, 2);
    run("srl31", C_SHIFT, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 2'b00, 2'b01, 32'h0000_0001, 1'b0, 32);
    run("ror4",  C_SHIFT, 32'h0000_0001, 32'd4,  1'b0, 1'b0, 2'b00, 2'b11, 32'h1000_0000, 1'b0, 5);

    // Popcount and LUI
    run("pop12", C_POPC, 32'hF0F0_000F, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd12, 1'b0, 5);
    run("pop32", C_POPC, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd32, 1'b0, 5);
    run("pop0",  C_POPC, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 5);
    run("lui",   C_LUI,  32'hFFFF_FFFF, 32'hABCD_1234, 1'b0, 1'b0, 2'b00, 2'b00, 32'h1234_0000, 1'b0, 2);

    // Backpressure: result held in DONE while a competing request is presented
    begin
      int lat;
      issue(C_ARITH, 32'd3, 32'd4, 1'b0, 1'b0, 2'b00, 2'b00);
      wait_done(lat);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        fn_class = C_ARITH;
        x        = 32'd100;
        y        = 32'd200;
        in_valid = 1'b1;
        chk("bp_result", result, 32'd7);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      drain();
      run("bp_next", C_ARITH, 32'd10, 32'd20, 1'b0, 1'b0, 2'b00, 2'b00, 32'd30, 1'b0, 2);
    end

    // Reset in the middle of a 10-step shift abandons it
    issue(C_SHIFT, 32'h1, 32'd10, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_output", {31'b0, seen}, 32'd0);
    run("lui_after_rst", C_LUI, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 2'b00, 2'b00, 32'h1234_0000, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
